spi_tx_feed: RTL and testbench
==============================

# spi_tx_feed

Word-buffering feeder that sits directly upstream of the SPI transmit shifter. Accepts 16-bit words from a host write port into a small FIFO and answers the shifter's toggle-style load handshake by presenting the next word on its data bus. It runs on the same clock as the shifter. It reports level, full/empty, and sticky overflow/underrun status.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..256
- LW, $clog2(DEPTH)+1, width of o_level (derived, not overridden)
- i_clock  in  1  single clock, shared with the shifter; all state on posedge
- i_reset  in  1  asynchronous, active-high reset
- i_wr_en  in  1  host write strobe, one word per cycle
- i_wr_data  in  16  host word
- i_load_req  in  1  toggle request from shifter: current word consumed
- i_clr_flags  in  1  clears o_overflow and o_underrun
- o_data  out  16  word presented to shifter
- o_load_ack  out  1  toggle acknowledge to shifter
- o_level  out  LW  words stored, 0..DEPTH
- o_empty  out  1  o_level == 0
- o_full  out  1  o_level == DEPTH
- o_overflow  out  1  sticky: write attempted while full
- o_underrun  out  1  sticky: load pending while empty

## Operation
- Load pending is defined as pend = (i_load_req != o_load_ack). While pend=0 the shifter is shifting o_data. While pend=1 the shifter idles.
- Serve: on an edge with pend=1 and o_empty=0:
  - o_data <= mem[rd_ptr]
  - rd_ptr <= rd_ptr+1, wrapping at DEPTH
  - o_load_ack <= i_load_req
- o_data is stable whenever pend=0. It changes only on a serve edge.
- Write: on an edge with i_wr_en=1 and o_full=0, mem[wr_ptr] <= i_wr_data and wr_ptr advances with wrap.
- Write while full: the word is dropped, pointers are unchanged, and o_overflow <= 1.
- Underrun: on an edge with pend=1 and o_empty=1, o_underrun <= 1 and ack is unchanged (the shifter keeps idling). Underrun is not flagged before the first word has ever been served.
- Simultaneous write and serve: both take effect and o_level is unchanged.
- Write into an empty FIFO while pend=1: the word is stored this edge. The serve happens on the next edge, because empty is evaluated pre-edge; there is no bypass path.
- i_clr_flags clears both sticky flags. If a set condition occurs on the same edge, set wins.
- Full/empty are derived from o_level, which is maintained as a counter: +1 on write only, -1 on serve only, unchanged on both or neither.

## Timing
- Reset values:
  - o_data=0, o_load_ack=1, o_level=0, o_empty=1, o_full=0, o_overflow=0, o_underrun=0
  - rd_ptr=wr_ptr=0
- Because the shifter resets its request to 0, o_load_ack=1 makes pend=1, so the shifter idles until the first word is served. It never shifts the reset value of o_data.
- Serve latency: the edge after the shifter toggles its request, pend is seen and the word/ack are registered. The shifter samples the matching ack on the following edge.
- This inherent one idle bit-clock gap per word is accepted; no lookahead.
- Write-to-available: a written word is servable from the next edge.
- Reset mid-operation:
  - FIFO contents are discarded and all outputs return to reset values immediately (async).
  - The shifter is reset by the same signal, so the handshake resynchronises with pend=1.
- Pointers are log2(DEPTH) bits with natural wrap. o_level never exceeds DEPTH.

## Test plan
- Reset idle:
  - Stimulus: assert i_reset, release, no writes for 20 clocks.
  - Required: o_load_ack=1, o_empty=1, o_underrun=0, o_data=0; the shifter output clock stays at CPOL.
- Single word:
  - Stimulus: write 0xA5C3, then run the shifter with width 8.
  - Required: o_data=0xA5C3 and ack toggles 2 edges after the write. After the word completes and the request toggles, o_underrun=1 and o_level=0.
- Back-to-back stream:
  - Stimulus: write 0x0001..0x0008 with DEPTH=8.
  - Required: o_full=1 after the 8th write. Words are served in order with one idle clock between words. o_level decrements to 0 and o_overflow stays 0.
- Overflow:
  - Stimulus: fill 8 words, then write 0xDEAD while full.
  - Required: o_overflow=1, o_level=8, and 0xDEAD never appears on o_data. Pulse i_clr_flags and o_overflow returns to 0.
- Simultaneous write and serve at level 3:
  - Required: o_level stays 3 and data order is preserved.
- Wrap and mid-operation reset:
  - Stimulus: stream 20 words through DEPTH=8, checking order across pointer wrap. Assert i_reset during the 12th word.
  - Required: all outputs return to reset values at once. A post-reset write of 0x1234 is the next word served.

Source files
------------

// File: rtl/spi_tx_feed.sv
// Word FIFO feeding the SPI transmit shifter through a toggle load handshake.
// Serves the next word whenever the shifter's request differs from our ack.
module spi_tx_feed #(
    parameter int DEPTH = 8,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_wr_en,
    input  logic [15:0]   i_wr_data,
    input  logic          i_load_req,
    input  logic          i_clr_flags,
    output logic [15:0]   o_data,
    output logic          o_load_ack,
    output logic [LW-1:0] o_level,
    output logic          o_empty,
    output logic          o_full,
    output logic          o_overflow,
    output logic          o_underrun
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [15:0]   r_data;
    logic          r_ack;
    logic          r_overflow;
    logic          r_underrun;
    logic          r_served;

    logic w_pend;
    logic w_empty;
    logic w_full;
    logic w_serve;
    logic w_write;
    logic w_ovf_set;
    logic w_unr_set;

    always_comb begin
        w_pend    = (i_load_req != r_ack);
        w_empty   = (r_level == '0);
        w_full    = (r_level == FULL_LEVEL);
        w_serve   = w_pend & ~w_empty;
        w_write   = i_wr_en & ~w_full;
        w_ovf_set = i_wr_en & w_full;
        // An idle shifter straight out of reset is not starved yet.
        w_unr_set = w_pend & w_empty & r_served;
    end

    always_ff @(posedge i_clock) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_data     <= '0;
            r_ack      <= 1'b1;
            r_overflow <= 1'b0;
            r_underrun <= 1'b0;
            r_served   <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_serve) begin
                r_data   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_ack    <= i_load_req;
                r_served <= 1'b1;
            end
            case ({w_write, w_serve})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            r_overflow <= (r_overflow & ~i_clr_flags) | w_ovf_set;
            r_underrun <= (r_underrun & ~i_clr_flags) | w_unr_set;
        end
    end

    always_comb begin
        o_data     = r_data;
        o_load_ack = r_ack;
        o_level    = r_level;
        o_empty    = w_empty;
        o_full     = w_full;
        o_overflow = r_overflow;
        o_underrun = r_underrun;
    end

endmodule

// File: tb/tb_spi_tx_feed.sv
// Self-checking bench for spi_tx_feed: directed vector table, reset/latency
// sequence, then randomized traffic against a queue-based reference model.
module tb_spi_tx_feed;

    localparam int DEPTH = 8;
    localparam int LW = $clog2(DEPTH) + 1;

    logic          i_clock = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_wr_en = 1'b0;
    logic [15:0]   i_wr_data = '0;
    logic          i_load_req = 1'b0;
    logic          i_clr_flags = 1'b0;
    logic [15:0]   o_data;
    logic          o_load_ack;
    logic [LW-1:0] o_level;
    logic          o_empty;
    logic          o_full;
    logic          o_overflow;
    logic          o_underrun;

    int n_checks = 0;
    int n_fail   = 0;

    spi_tx_feed #(.DEPTH(DEPTH)) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_wr_en    (i_wr_en),
        .i_wr_data  (i_wr_data),
        .i_load_req (i_load_req),
        .i_clr_flags(i_clr_flags),
        .o_data     (o_data),
        .o_load_ack (o_load_ack),
        .o_level    (o_level),
        .o_empty    (o_empty),
        .o_full     (o_full),
        .o_overflow (o_overflow),
        .o_underrun (o_underrun)
    );

    always #5 i_clock = ~i_clock;

    // Reference model: the FIFO is a queue; everything is decided from pre-edge state.
    logic [15:0] m_q[$];
    logic [15:0] m_data;
    logic        m_ack, m_ovf, m_unr, m_served;

    task automatic model_reset();
        m_q.delete();
        m_data = 16'h0; m_ack = 1'b1; m_ovf = 1'b0; m_unr = 1'b0; m_served = 1'b0;
    endtask

    task automatic model_step(input logic wr, input logic [15:0] wd, input logic req, input logic clr);
        logic pend, was_empty, was_full;
        pend      = (req != m_ack);
        was_empty = (m_q.size() == 0);
        was_full  = (m_q.size() == DEPTH);
        m_ovf = (m_ovf & ~clr) | (wr & was_full);
        m_unr = (m_unr & ~clr) | (pend & was_empty & m_served);
        if (pend && !was_empty) begin
            m_data = m_q.pop_front();
            m_ack = req;
            m_served = 1'b1;
        end
        if (wr && !was_full) m_q.push_back(wd);
    endtask

    task automatic check(input string name, input logic [15:0] e_data, input logic e_ack,
                         input int e_lvl, input logic e_ovf, input logic e_unr);
        n_checks++;
        if (o_data !== e_data || o_load_ack !== e_ack || o_level !== LW'(e_lvl) ||
            o_empty !== (e_lvl == 0) || o_full !== (e_lvl == DEPTH) ||
            o_overflow !== e_ovf || o_underrun !== e_unr) begin
            n_fail++;
            $display("FAIL %s: got data=%h ack=%b lvl=%0d emp=%b full=%b ovf=%b unr=%b; want data=%h ack=%b lvl=%0d ovf=%b unr=%b",
                     name, o_data, o_load_ack, o_level, o_empty, o_full, o_overflow, o_underrun,
                     e_data, e_ack, e_lvl, e_ovf, e_unr);
        end
    endtask

    task automatic check_model(input string name);
        check(name, m_data, m_ack, m_q.size(), m_ovf, m_unr);
    endtask

    task automatic drive(input logic wr, input logic [15:0] wd, input logic req, input logic clr);
        i_wr_en = wr; i_wr_data = wd; i_load_req = req; i_clr_flags = clr;
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] wd;
        logic        req;
        logic        clr;
        logic [15:0] e_data;
        logic        e_ack;
        int          e_lvl;
        logic        e_ovf;
        logic        e_unr;
    } vec_t;

    vec_t vecs[19];

    task automatic do_reset();
        @(negedge i_clock);
        i_reset = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge i_clock);
        i_reset = 1'b0;
        model_reset();
    endtask

    initial begin
        // Rows: inputs applied for one edge, then the outputs expected after it.
        vecs[0]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 16'hA5C3, 1'b0, 1'b0, 16'h0000, 1'b1, 1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'hA5C3, 1'b0, 0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'hA5C3, 1'b0, 0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hA5C3, 1'b0, 0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 16'h1111, 1'b1, 1'b0, 16'hA5C3, 1'b0, 1, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1111, 1'b1, 0, 1'b0, 1'b0};
        for (int k = 0; k < 8; k++)
            vecs[7+k] = '{1'b1, 16'(k + 1), 1'b1, 1'b0, 16'h1111, 1'b1, k + 1, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 16'hDEAD, 1'b1, 1'b0, 16'h1111, 1'b1, 8, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 16'h0009, 1'b0, 1'b0, 16'h0001, 1'b0, 7, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 7, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 16'h000A, 1'b1, 1'b0, 16'h0002, 1'b1, 7, 1'b0, 1'b0};

        do_reset();
        check("reset_state", 16'h0, 1'b1, 0, 1'b0, 1'b0);
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].wr, vecs[i].wd, vecs[i].req, vecs[i].clr);
            @(negedge i_clock);
            check($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_ack,
                  vecs[i].e_lvl, vecs[i].e_ovf, vecs[i].e_unr);
        end

        // Async reset mid-operation, then first post-reset word and its serve latency.
        drive(1'b0, 16'h0, 1'b0, 1'b0);
        #2 i_reset = 1'b1;
        #1 check("async_reset", 16'h0, 1'b1, 0, 1'b0, 1'b0);
        #1 i_reset = 1'b0;
        for (int i = 0; i < 20; i++) @(negedge i_clock);
        check("reset_idle", 16'h0, 1'b1, 0, 1'b0, 1'b0);
        drive(1'b1, 16'h1234, 1'b0, 1'b0);
        begin
            int edges = 0;
            @(negedge i_clock);
            edges = 1;
            drive(1'b0, 16'h0, 1'b0, 1'b0);
            while (o_load_ack !== 1'b0 && edges < 6) begin
                @(negedge i_clock);
                edges++;
            end
            n_checks++;
            if (edges != 2) begin
                n_fail++;
                $display("FAIL serve_latency: got %0d edges, want 2", edges);
            end
            check("post_reset_word", 16'h1234, 1'b0, 0, 1'b0, 1'b0);
        end

        // Randomized traffic with shifter-like requests and one async reset mid-stream.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic wr, req, clr;
            logic [15:0] wd;
            @(negedge i_clock);
            check_model($sformatf("rand%0d", c));
            if (c == 1700) begin
                #1 i_reset = 1'b1;
                model_reset();
                i_load_req = 1'b0;
                #1 check_model("rand_reset");
                #1 i_reset = 1'b0;
            end
            wr  = ((c / 150) % 2 == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
            wd  = 16'($urandom);
            clr = ($urandom_range(0, 15) == 0);
            req = i_load_req;
            if (req == m_ack && $urandom_range(0, 2) == 0) req = ~req;
            drive(wr, wd, req, clr);
            model_step(wr, wd, req, clr);
        end
        @(negedge i_clock);
        check_model("rand_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

endmodule
